// File: rtl/setting_reg_bank_masked.sv
// rtl/setting_reg_bank_masked.sv - masked settings-register bank with toggle, autoclear and shadow commit
// Live bits in AUTOCLR_MASK decay to 0 unless the same edge writes them; shadow regs never decay.
module setting_reg_bank_masked #(
  parameter int               base_addr    = 0,
  parameter int               NREGS        = 4,
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] AUTOCLR_MASK = '0,
  parameter bit               SHADOW       = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   strobe,
  input  logic [6:0]             addr,
  input  logic [31:0]            in,
  input  logic [6:0]             rd_addr,
  output logic [NREGS*WIDTH-1:0] out,
  output logic [NREGS-1:0]       changed,
  output logic [31:0]            rd_data
);

  logic [NREGS-1:0][WIDTH-1:0] live_q, live_d;
  logic [NREGS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NREGS-1:0][WIDTH-1:0] base_val, upd_val;
  logic [NREGS-1:0]            changed_q, changed_d;
  logic [NREGS-1:0]            wr_hit, tg_hit, commit_sel;
  logic [31:0]                 rd_data_q, rd_data_d;
  logic [WIDTH-1:0]            m, v;
  logic                        commit_hit;

  assign m          = in[16 +: WIDTH];
  assign v          = in[0 +: WIDTH];
  assign commit_hit = strobe && (addr == 7'(base_addr + 2 * NREGS));

  always_comb begin
    wr_hit     = '0;
    tg_hit     = '0;
    commit_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_hit[i]     = strobe && (addr == 7'(base_addr + i));
      tg_hit[i]     = strobe && (addr == 7'(base_addr + NREGS + i));
      commit_sel[i] = SHADOW && commit_hit && in[i];
    end
  end

  // Bits outside m take the decayed value, so an untouched autoclear bit still drops.
  always_comb begin
    base_val = '0;
    upd_val  = '0;
    for (int i = 0; i < NREGS; i++) begin
      base_val[i] = SHADOW ? shadow_q[i] : (live_q[i] & ~AUTOCLR_MASK);
      if (wr_hit[i]) begin
        upd_val[i] = (base_val[i] & ~m) | (v & m);
      end else if (tg_hit[i]) begin
        upd_val[i] = (base_val[i] & ~m) | (((SHADOW ? shadow_q[i] : live_q[i]) ^ m) & m);
      end else begin
        upd_val[i] = base_val[i];
      end
    end
  end

  always_comb begin
    live_d    = live_q;
    shadow_d  = shadow_q;
    changed_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (SHADOW) begin
        shadow_d[i]  = upd_val[i];
        live_d[i]    = commit_sel[i] ? shadow_q[i] : (live_q[i] & ~AUTOCLR_MASK);
        changed_d[i] = commit_sel[i];
      end else begin
        live_d[i]    = upd_val[i];
        changed_d[i] = wr_hit[i] | tg_hit[i];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == 7'(base_addr + i)) begin
        rd_data_d = 32'(live_q[i]);
      end
      if (rd_addr == 7'(base_addr + NREGS + i)) begin
        rd_data_d = SHADOW ? 32'(shadow_q[i]) : 32'(live_q[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q    <= '0;
      shadow_q  <= '0;
      changed_q <= '0;
      rd_data_q <= '0;
    end else begin
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      changed_q <= changed_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign out     = live_q;
  assign changed = changed_q;
  assign rd_data = rd_data_q;

endmodule

// File: doc/setting_reg_bank_masked.md
Name: setting_reg_bank_masked

Overview:
- Parametrised bank of NREGS masked setting registers on the settings bus (strobe/addr/in), decoded from a contiguous address window starting at base_addr.
- Adds three features to per-bit masked writes:
  - masked toggle;
  - self-clearing (pulse) bits;
  - optional shadow staging with an atomic multi-register commit.
- Registered readback port feeds status/readback muxes.

Parameters:
- base_addr, 0: first settings address of the window; window spans base_addr..base_addr+2*NREGS (must be <=127).
- NREGS, 4: number of registers, 1..16.
- WIDTH, 16: bits per register, 1..16.
- AUTOCLR_MASK, 0 (WIDTH bits): bits that self-clear one cycle after being set; same mask applies to every register.
- SHADOW, 0: 0 means writes/toggles hit live registers; 1 means they hit shadow registers, and live registers update only on commit.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- strobe  in  1  settings-bus write strobe.
- addr  in  7  settings-bus address.
- in  in  32  settings-bus data; [31:16] = mask, [15:0] = value.
- rd_addr  in  7  readback address, same map as writes.
- out  out  NREGS*WIDTH  live register values, reg i at [i*WIDTH +: WIDTH].
- changed  out  NREGS  one-cycle pulse per register on live update.
- rd_data  out  32  registered readback, zero-extended.

Behaviour:
- Reset (reset==0, async): out, all shadow regs, changed and rd_data go to 0 immediately, held until release. Reset mid-operation discards staged shadow data.
- Field use: m = in[16 +: WIDTH], v = in[0 +: WIDTH]; upper bits of each half are ignored.
- Address decode, with strobe high (offsets from base_addr):
  - base+i, masked write: target = (target & ~m) | (v & m).
  - base+NREGS+i, masked toggle: target = target ^ m; v ignored.
  - base+2*NREGS, commit: in[NREGS-1:0] selects registers; for each set bit i, out[i] <= shadow[i]. In SHADOW=0 the commit address is a no-op.
  - Any other address, or strobe low: no write.
- Write target: live reg when SHADOW=0; shadow reg when SHADOW=1.
- changed, registered and aligned with the edge on which out updates:
  - SHADOW=0: changed[i]=1 for exactly the cycle after any write or toggle to reg i, including when m==0 or the value is unchanged.
  - SHADOW=1: changed[i]=1 only for registers named in a commit; writes and toggles to shadow never pulse changed.
  - Otherwise changed=0.
- Autoclear:
  - Any live bit b with AUTOCLR_MASK[b]=1 that is 1 is forced to 0 on the next edge, unless that same edge writes, toggles or commits it to 1 again.
  - Result: a single write of 1 produces a one-cycle pulse on out.
  - Autoclear never asserts changed. Shadow registers are not autocleared.
- Readback, 1-cycle latency: rd_data at edge n+1 reflects rd_addr at edge n, sampled after that edge's update.
  - base+i returns live reg i.
  - base+NREGS+i returns shadow reg i (live reg i when SHADOW=0).
  - Any other address returns 0.
- Single address per cycle, so write, toggle and commit are mutually exclusive; no arbitration is needed.
- NREGS=1 is legal: window is base, base+1 (toggle), base+2 (commit).

Test Plan (NREGS=4, WIDTH=16, base_addr=8, AUTOCLR_MASK=16'h8000 unless noted):
- Reset check: drive reset=0 mid-cycle with out[reg0]=16'h00FF and changed=1 -> out=0, changed=0, rd_data=0 immediately, without waiting for a clock edge.
- Masked write then toggle, SHADOW=0:
  - strobe addr=9 in=32'h00FF_00A5 -> reg1=16'h00A5, changed=4'b0010 for one cycle.
  - Then addr=13 in=32'h000F_0000 -> reg1=16'h00AA, changed=4'b0010.
  - Then addr=9 in=32'h0000_FFFF -> reg1 unchanged, changed still pulses.
- Autoclear:
  - addr=8 in=32'h8001_8001 -> reg0=16'h8001 for one cycle, then 16'h0001; changed pulses once only.
  - Back-to-back identical writes -> bit15 stays 1 for two cycles.
- Shadow/commit, SHADOW=1:
  - Writes addr=8 in=32'hFFFF_1234 and addr=10 in=32'hFFFF_5678 -> out unchanged, changed=0.
  - Readback rd_addr=12 -> 16'h1234; rd_addr=8 -> 0.
  - Commit addr=16 in=32'h5 -> reg0=16'h1234, reg2=16'h5678 on the same edge, changed=4'b0101.
- Decode bounds: strobe at addr=7 and addr=17 (any data) -> no register changes, changed=0; rd_addr=7 -> rd_data=0 one cycle later.
- Readback latency: rd_addr switches 8->9->10 on consecutive edges -> rd_data follows one cycle later, zero-extended to 32 bits.
